// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Brief    : BCD digit type and 7-segment code table shared by the counter.
// Revision : 1.0
// ============================================================================
package counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Bit positions of the digit-select and decimal-point fields.
    localparam int c_seg_bit = 8;
    localparam int c_dp_bit  = 7;

    localparam logic [8:0] c_seg_blank = 9'h000;

    localparam logic [8:0] c_seg_table [10] = '{
        9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066,
        9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h06F
    };

    function automatic logic [8:0] seg7_encode(input bcd_digit_t d);
        logic [8:0] code;
        code = c_seg_blank;
        if (d <= 4'd9) begin
            code = c_seg_table[d];
        end
        code[c_seg_bit] = 1'b0;
        code[c_dp_bit]  = 1'b0;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-flop synchronizer and debouncer for an active-low push button.
// Revision : 1.0
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYC = 240_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_in,
    output logic press_pulse,
    output logic level
);

    localparam int c_cw = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DEBOUNCE_CYC - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [c_cw-1:0] r_cnt;
    logic            w_diff;
    logic            w_accept;

    assign w_diff   = (r_sync2 != r_level);
    assign w_accept = w_diff && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_n_in;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the run.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press_pulse = w_accept & ~r_sync2;
    assign level       = r_level;

endmodule
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter
// Brief    : Two-digit BCD modulo up/down counter with start/pause key,
//            synchronous load and 7-segment outputs.
// Revision : 1.0
// ============================================================================
module bcd_mod_counter
    import counter_pkg::*;
#(
    parameter int MODULUS      = 60,
    parameter int TICK_DIV     = 12_000_000,
    parameter int DEBOUNCE_CYC = 240_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry,
    output logic       running,
    output logic [8:0] seg_tens,
    output logic [8:0] seg_ones
);

    localparam int c_pw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(TICK_DIV - 1);
    localparam bcd_digit_t c_max_tens = 4'((MODULUS - 1) / 10);
    localparam bcd_digit_t c_max_ones = 4'((MODULUS - 1) % 10);

    logic [c_pw-1:0] r_presc;
    bcd_digit_t      r_tens;
    bcd_digit_t      r_ones;
    logic            r_carry;
    logic            r_running;

    logic            w_tick;
    logic            w_press_pulse;
    logic            w_key_level;
    logic            w_press;
    bcd_digit_t      w_ld_tens;
    bcd_digit_t      w_ld_ones;
    logic            w_ld_ok;
    bcd_digit_t      w_tens_nxt;
    bcd_digit_t      w_ones_nxt;
    logic            w_carry_nxt;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk         (clk),
        .rst         (rst),
        .key_n_in    (key),
        .press_pulse (w_press_pulse),
        .level       (w_key_level)
    );

    // A press is only ever taken from the released state.
    assign w_press = w_press_pulse & w_key_level;
    assign w_tick  = (r_presc == c_presc_last);

    assign w_ld_tens = load_val[7:4];
    assign w_ld_ones = load_val[3:0];
    assign w_ld_ok   = (w_ld_tens <= 4'd9) && (w_ld_ones <= 4'd9) &&
                       (({4'd0, w_ld_tens} * 8'd10 + {4'd0, w_ld_ones}) < 8'(MODULUS));

    always_comb begin
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_carry_nxt = 1'b0;
        if (load) begin
            w_tens_nxt = w_ld_ok ? w_ld_tens : 4'd0;
            w_ones_nxt = w_ld_ok ? w_ld_ones : 4'd0;
        end else if (w_tick && r_running) begin
            if (dir) begin
                if (r_tens == c_max_tens && r_ones == c_max_ones) begin
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                    w_carry_nxt = 1'b1;
                end else if (r_ones == 4'd9) begin
                    w_ones_nxt = 4'd0;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_ones_nxt = r_ones + 4'd1;
                end
            end else begin
                if (r_tens == 4'd0 && r_ones == 4'd0) begin
                    w_tens_nxt  = c_max_tens;
                    w_ones_nxt  = c_max_ones;
                    w_carry_nxt = 1'b1;
                end else if (r_ones == 4'd0) begin
                    w_ones_nxt = 4'd9;
                    w_tens_nxt = r_tens - 4'd1;
                end else begin
                    w_ones_nxt = r_ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_carry   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + 1'b1;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_carry   <= w_carry_nxt;
            // The count decision above already used the pre-toggle state.
            if (w_press) begin
                r_running <= ~r_running;
            end
        end
    end

    assign tens     = r_tens;
    assign ones     = r_ones;
    assign carry    = r_carry;
    assign running  = r_running;
    assign seg_tens = seg7_encode(r_tens);
    assign seg_ones = seg7_encode(r_ones);

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_mod_counter
// Brief    : Directed self-checking bench, MODULUS=24 TICK_DIV=4 DEBOUNCE_CYC=3.
// Revision : 1.0
// ============================================================================
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       carry;
    logic       running;
    logic [8:0] seg_tens;
    logic [8:0] seg_ones;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bcd_mod_counter #(
        .MODULUS      (24),
        .TICK_DIV     (4),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .tens     (tens),
        .ones     (ones),
        .carry    (carry),
        .running  (running),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones)
    );

    always #5 clk = ~clk;

    // Bench copy of the prescaler phase: tick is high while cyc % 4 == 3.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to just after the next counting edge.
    task automatic tick_edge();
        for (int i = 0; i < 4 && (cyc % 4) != 3; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step(1);
        load     = 1'b0;
    endtask

    function automatic logic [7:0] cnt();
        return {tens, ones};
    endfunction

    initial begin
        rst = 1'b1; key = 1'b1; dir = 1'b1; load = 1'b0; load_val = 8'h00;
        step(3);
        check_val("rst_count",   {24'd0, cnt()}, 32'h00);
        check_val("rst_carry",   {31'd0, carry}, 32'd0);
        check_val("rst_running", {31'd0, running}, 32'd0);
        check_val("rst_seg_t",   {23'd0, seg_tens}, 32'h03F);
        check_val("rst_seg_o",   {23'd0, seg_ones}, 32'h03F);

        // Clean press: 2 sync + 3 debounce cycles.
        rst = 1'b0;
        key = 1'b0;
        step(4);
        check_val("press_early", {31'd0, running}, 32'd0);
        step(1);
        check_val("press_run",   {31'd0, running}, 32'd1);
        check_val("press_cnt0",  {24'd0, cnt()}, 32'h00);
        tick_edge();
        check_val("up_01",       {24'd0, cnt()}, 32'h01);
        step(4);
        check_val("up_02",       {24'd0, cnt()}, 32'h02);

        // Up-count wrap at MODULUS-1.
        do_load(8'h22);
        check_val("ld_22",       {24'd0, cnt()}, 32'h22);
        tick_edge();
        check_val("up_23",       {24'd0, cnt()}, 32'h23);
        check_val("up_23_carry", {31'd0, carry}, 32'd0);
        check_val("seg_t_2",     {23'd0, seg_tens}, 32'h05B);
        check_val("seg_o_3",     {23'd0, seg_ones}, 32'h04F);
        tick_edge();
        check_val("up_wrap",     {24'd0, cnt()}, 32'h00);
        check_val("up_carry",    {31'd0, carry}, 32'd1);
        step(1);
        check_val("up_carry_end", {31'd0, carry}, 32'd0);
        do_load(8'h09);
        tick_edge();
        check_val("up_09_10",    {24'd0, cnt()}, 32'h10);

        // Down count and underflow wrap.
        dir = 1'b0;
        do_load(8'h01);
        tick_edge();
        check_val("dn_00",       {24'd0, cnt()}, 32'h00);
        check_val("dn_00_carry", {31'd0, carry}, 32'd0);
        tick_edge();
        check_val("dn_wrap",     {24'd0, cnt()}, 32'h23);
        check_val("dn_carry",    {31'd0, carry}, 32'd1);
        step(1);
        check_val("dn_carry_end", {31'd0, carry}, 32'd0);
        do_load(8'h10);
        tick_edge();
        check_val("dn_10_09",    {24'd0, cnt()}, 32'h09);
        dir = 1'b1;

        // Release, then a bouncing press gives exactly one toggle.
        key = 1'b1;
        step(8);
        check_val("release_run", {31'd0, running}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        key = 1'b0;
        step(8);
        check_val("bounce_toggle", {31'd0, running}, 32'd0);
        step(10);
        check_val("held_no_toggle", {31'd0, running}, 32'd0);
        key = 1'b1; step(8);
        key = 1'b0; step(8);
        check_val("press2_run",  {31'd0, running}, 32'd1);
        key = 1'b1; step(8);
        key = 1'b0; step(8);
        check_val("press3_pause", {31'd0, running}, 32'd0);
        do_load(8'h15);
        check_val("ld_paused",   {24'd0, cnt()}, 32'h15);
        step(12);
        check_val("frozen",      {24'd0, cnt()}, 32'h15);
        key = 1'b1; step(8);
        key = 1'b0; step(8);
        check_val("press4_run",  {31'd0, running}, 32'd1);

        // Load coincident with tick: loaded value, no increment.
        for (int i = 0; i < 4 && (cyc % 4) != 3; i++) step(1);
        do_load(8'h19);
        check_val("ld_19_tick",  {24'd0, cnt()}, 32'h19);
        check_val("ld_19_carry", {31'd0, carry}, 32'd0);
        check_val("seg_t_1",     {23'd0, seg_tens}, 32'h006);
        check_val("seg_o_9",     {23'd0, seg_ones}, 32'h06F);
        tick_edge();
        check_val("up_20",       {24'd0, cnt()}, 32'h20);
        do_load(8'h1A);
        check_val("ld_1A",       {24'd0, cnt()}, 32'h00);
        do_load(8'h23);
        check_val("ld_23",       {24'd0, cnt()}, 32'h23);
        do_load(8'h25);
        check_val("ld_25",       {24'd0, cnt()}, 32'h00);

        // Reset at 23 coincident with a wrapping tick.
        for (int i = 0; i < 4 && (cyc % 4) != 2; i++) step(1);
        do_load(8'h23);
        rst = 1'b1;
        step(1);
        check_val("rst_tick_cnt",   {24'd0, cnt()}, 32'h00);
        check_val("rst_tick_carry", {31'd0, carry}, 32'd0);
        check_val("rst_tick_run",   {31'd0, running}, 32'd0);
        check_val("rst_tick_seg_t", {23'd0, seg_tens}, 32'h03F);
        check_val("rst_tick_seg_o", {23'd0, seg_ones}, 32'h03F);
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
